// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding or interlock; optional macro FORWARD_EN.
// Latency: one cycle from accept to ex_valid; operand muxing is combinational on the EX side.
// Backpressure: holds payload while ex_ready=0; id_ready drops on a full stage or a hazard.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [3:0]  id_alu_ctrl,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic        id_use_imm,
  input  logic [31:0] id_pc,
  input  logic        id_use_pc,
  input  logic [4:0]  id_rd_addr,
  input  logic        id_rd_wen,
  input  logic [4:0]  mem_rd_addr,
  input  logic        mem_rd_wen,
  input  logic [31:0] mem_rd_data,
  input  logic [4:0]  wb_rd_addr,
  input  logic        wb_rd_wen,
  input  logic [31:0] wb_rd_data,
  output logic        ex_valid,
  input  logic        ex_ready,
  input  logic        flush,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] alu_datain1,
  output logic [31:0] alu_datain2,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rd_addr,
  output logic        ex_rd_wen,
  output logic        hazard_stall
);

  logic [3:0]  alu_ctrl_q;
  logic [31:0] rs1_data_q;
  logic [31:0] rs2_data_q;
  logic [31:0] imm_q;
  logic [31:0] pc_q;
  logic        use_imm_q;
  logic        use_pc_q;
  logic [4:0]  rd_addr_q;
  logic        rd_wen_q;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        accept;

  assign id_ready = (ex_ready || !ex_valid) && !hazard_stall;
  assign accept   = id_valid && id_ready;

  // flush wins over accept; an instr offered alongside a flush is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid <= 1'b1;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ctrl_q <= 4'd0;
      rs1_data_q <= 32'd0;
      rs2_data_q <= 32'd0;
      imm_q      <= 32'd0;
      pc_q       <= 32'd0;
      use_imm_q  <= 1'b0;
      use_pc_q   <= 1'b0;
      rd_addr_q  <= 5'd0;
      rd_wen_q   <= 1'b0;
    end else if (accept && !flush) begin
      alu_ctrl_q <= id_alu_ctrl;
      rs1_data_q <= id_rs1_data;
      rs2_data_q <= id_rs2_data;
      imm_q      <= id_imm;
      pc_q       <= id_pc;
      use_imm_q  <= id_use_imm;
      use_pc_q   <= id_use_pc;
      rd_addr_q  <= id_rd_addr;
      rd_wen_q   <= id_rd_wen;
    end
  end

`ifdef FORWARD_EN
  logic [4:0] rs1_addr_q;
  logic [4:0] rs2_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_addr_q <= 5'd0;
      rs2_addr_q <= 5'd0;
    end else if (accept && !flush) begin
      rs1_addr_q <= id_rs1_addr;
      rs2_addr_q <= id_rs2_addr;
    end
  end

  // MEM is younger than WB so it wins; x0 is hardwired and never forwarded
  always_comb begin
    rs1_val = rs1_data_q;
    if (rs1_addr_q != 5'd0 && mem_rd_wen && mem_rd_addr == rs1_addr_q)
      rs1_val = mem_rd_data;
    else if (rs1_addr_q != 5'd0 && wb_rd_wen && wb_rd_addr == rs1_addr_q)
      rs1_val = wb_rd_data;
    rs2_val = rs2_data_q;
    if (rs2_addr_q != 5'd0 && mem_rd_wen && mem_rd_addr == rs2_addr_q)
      rs2_val = mem_rd_data;
    else if (rs2_addr_q != 5'd0 && wb_rd_wen && wb_rd_addr == rs2_addr_q)
      rs2_val = wb_rd_data;
  end

  assign hazard_stall = 1'b0;
`else
  function automatic logic pending_write(input logic [4:0] a);
    return (a != 5'd0) &&
           ((ex_valid && rd_wen_q && rd_addr_q == a) ||
            (mem_rd_wen && mem_rd_addr == a) ||
            (wb_rd_wen && wb_rd_addr == a));
  endfunction

  logic unused_fwd_data;

  assign rs1_val         = rs1_data_q;
  assign rs2_val         = rs2_data_q;
  assign hazard_stall    = id_valid && (pending_write(id_rs1_addr) ||
                                        (!id_use_imm && pending_write(id_rs2_addr)));
  assign unused_fwd_data = ^{mem_rd_data, wb_rd_data};
`endif

  assign alu_ctrl      = alu_ctrl_q;
  assign alu_datain1   = use_pc_q  ? pc_q  : rs1_val;
  assign alu_datain2   = use_imm_q ? imm_q : rs2_val;
  assign ex_store_data = rs2_val;
  assign ex_rd_addr    = rd_addr_q;
  assign ex_rd_wen     = ex_valid && rd_wen_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 The module SHALL have these decode-side ports: id_valid in 1 instr offered; id_ready out 1 stage accepts; id_alu_ctrl in 4 ALU op code per core_defines.v; id_rs1_addr/id_rs2_addr in 5; id_rs1_data/id_rs2_data in 32 regfile reads; id_imm in 32; id_use_imm in 1 operand2 = imm; id_pc in 32; id_use_pc in 1 operand1 = pc; id_rd_addr in 5; id_rd_wen in 1.
REQ-003 The module SHALL have these forwarding-source ports: mem_rd_addr in 5, mem_rd_wen in 1, mem_rd_data in 32; wb_rd_addr in 5, wb_rd_wen in 1, wb_rd_data in 32.
REQ-004 The module SHALL have these execute-side ports: ex_valid out 1; ex_ready in 1 downstream accepts; flush in 1 kill held instr; alu_ctrl out 4; alu_datain1/alu_datain2 out 32; ex_store_data out 32 forwarded rs2; ex_rd_addr out 5; ex_rd_wen out 1; hazard_stall out 1.

Function
REQ-005 Accept SHALL occur on a clk edge where id_valid and id_ready are both 1; accepted payload SHALL appear on the outputs with ex_valid=1 exactly one cycle later.
REQ-006 id_ready SHALL be (ex_ready or not ex_valid) and not hazard_stall.
REQ-007 While ex_valid=1 and ex_ready=0, all registered payload and ex_valid SHALL hold.
REQ-008 When ex_valid=1, ex_ready=1, and there is no accept, ex_valid SHALL clear on the next edge.
REQ-009 Simultaneous drain and accept SHALL load the new instr with no bubble (back-to-back throughput 1/cycle).
REQ-010 flush=1 SHALL clear ex_valid on the next edge with priority over accept; an instr offered in that cycle SHALL be dropped, not buffered; id_ready SHALL still follow REQ-006.
REQ-011 Forwarded rs value (with FORWARD_EN): if reg addr != 0 and mem_rd_wen and mem_rd_addr matches, use mem_rd_data; else if wb_rd_wen and wb_rd_addr matches, use wb_rd_data; else use the registered regfile data. MEM SHALL have priority over WB. x0 SHALL never be forwarded.
REQ-012 alu_datain1 SHALL be the registered pc if use_pc, else forwarded rs1; alu_datain2 SHALL be the registered imm if use_imm, else forwarded rs2; ex_store_data SHALL be forwarded rs2 regardless of use_imm. All three SHALL be combinational from registers plus forwarding inputs.
REQ-013 When ex_valid=0, alu_ctrl, ex_rd_addr, ex_rd_wen, and the data outputs SHALL be ignored downstream, but ex_rd_wen SHALL be forced 0.

Reset
REQ-014 rst_n low SHALL asynchronously clear ex_valid and every payload register (ctrl, addrs, data, pc, imm, select bits) to 0; hazard_stall SHALL be 0 and id_ready SHALL be 1 out of reset.
REQ-015 Reset asserted mid-stall SHALL discard the held instr; the first post-reset accept SHALL behave as from empty.

Configuration
REQ-016 Macro FORWARD_EN SHALL compile the forwarding of REQ-011; in that build, hazard_stall SHALL be tied 0.
REQ-017 Without FORWARD_EN, outputs SHALL use registered regfile data directly. hazard_stall SHALL be 1 when id_valid=1 and a nonzero id_rs1_addr/id_rs2_addr (the latter only if not id_use_imm) matches any of: ex_rd_addr (ex_valid and ex_rd_wen), mem_rd_addr (mem_rd_wen), or wb_rd_addr (wb_rd_wen).

Verification
REQ-018 FORWARD_EN: accept ADD rs1=x5 (regfile 0x1), rs2=x6 (0x2) while mem writes x5=0x10 and wb writes x5=0x20, x6=0x30 -> next cycle alu_datain1=0x10, alu_datain2=0x30.
REQ-019 Accept with rs1=x0 while mem_rd_addr=0 and mem_rd_wen=1 with data 0xFFFF -> alu_datain1 = registered regfile value 0.
REQ-020 ex_ready=0 for 3 cycles with ex_valid=1 -> outputs stable and id_ready=0; then ex_ready=1 with id_valid=1 -> new instr appears the next cycle with no bubble.
REQ-021 flush=1 together with id_valid=1 and ex_ready=1 -> ex_valid=0 next cycle and the offered instr is lost.
REQ-022 No FORWARD_EN: ex holds rd=x7 with wen, id offers rs2=x7, use_imm=0 -> hazard_stall=1 and id_ready=0; with use_imm=1 -> hazard_stall=0.
REQ-023 rst_n pulsed low asynchronously mid-stall -> ex_valid=0 and all outputs 0 before the next clk edge.
